// File: rtl/maquina_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maquina_pkg: coffee machine state encodings and monitor err codes |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package maquina_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd1,
        ST_LIGAR     = 4'd2,
        ST_VERIFICAR = 4'd3,
        ST_ENCHER    = 4'd4,
        ST_MOER      = 4'd5,
        ST_COLOCAR   = 4'd6,
        ST_PASSAR    = 4'd7,
        ST_TAMPEAR   = 4'd8,
        ST_EXTRACAO  = 4'd9
    } maq_state_e;

    localparam logic [2:0] C_ERR_NONE        = 3'd0;
    localparam logic [2:0] C_ERR_INVALID     = 3'd1;
    localparam logic [2:0] C_ERR_ILLEGAL     = 3'd2;
    localparam logic [2:0] C_ERR_NO_START    = 3'd3;
    localparam logic [2:0] C_ERR_STUCK_START = 3'd4;
    localparam logic [2:0] C_ERR_REFILL      = 3'd5;
    localparam logic [2:0] C_ERR_RESET       = 3'd6;

    function automatic logic is_valid_state(input logic [3:0] s);
        return (s >= ST_IDLE) && (s <= ST_EXTRACAO);
    endfunction

    // Single successor for states whose next step is unconditional.
    function automatic logic [3:0] fixed_next(input logic [3:0] s);
        logic [3:0] n;
        n = 4'd0;
        case (s)
            ST_LIGAR:    n = ST_VERIFICAR;
            ST_ENCHER:   n = ST_VERIFICAR;
            ST_MOER:     n = ST_COLOCAR;
            ST_COLOCAR:  n = ST_PASSAR;
            ST_PASSAR:   n = ST_TAMPEAR;
            ST_TAMPEAR:  n = ST_EXTRACAO;
            ST_EXTRACAO: n = ST_IDLE;
            default:     n = 4'd0;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maquina_trans_check.sv
`default_nettype none
// +------------------------------------------------------------------+
// | maquina_trans_check: combinational legality check of one step     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module maquina_trans_check
    import maquina_pkg::*;
(
    input  logic [3:0] prev_state,
    input  logic       prev_start,
    input  logic [3:0] state,
    input  logic       filled,
    output logic       viol,
    output logic [2:0] code
);

    always_comb begin
        viol = 1'b0;
        code = C_ERR_NONE;
        if (!is_valid_state(state)) begin
            viol = 1'b1;
            code = C_ERR_INVALID;
        end else if (is_valid_state(prev_state)) begin
            case (prev_state)
                ST_IDLE: begin
                    if (state == ST_LIGAR) begin
                        if (!prev_start) begin
                            viol = 1'b1;
                            code = C_ERR_NO_START;
                        end
                    end else if (state == ST_IDLE) begin
                        if (prev_start) begin
                            viol = 1'b1;
                            code = C_ERR_STUCK_START;
                        end
                    end else begin
                        viol = 1'b1;
                        code = C_ERR_ILLEGAL;
                    end
                end
                ST_VERIFICAR: begin
                    if (state == ST_ENCHER || state == ST_MOER) begin
                        // Refill only when empty, grind only once filled.
                        if ((state == ST_ENCHER) == filled) begin
                            viol = 1'b1;
                            code = C_ERR_REFILL;
                        end
                    end else begin
                        viol = 1'b1;
                        code = C_ERR_ILLEGAL;
                    end
                end
                default: begin
                    if (state != fixed_next(prev_state)) begin
                        viol = 1'b1;
                        code = C_ERR_ILLEGAL;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/monitor_maquina.sv
`default_nettype none
// +------------------------------------------------------------------+
// | monitor_maquina: protocol monitor and brew counter for the FSM    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module monitor_maquina
    import maquina_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic       start,
    input  logic       err_clr,
    output logic       busy,
    output logic       cafe_done,
    output logic [7:0] cafe_count,
    output logic       refill_seen,
    output logic       err,
    output logic [2:0] err_code
);

    logic [3:0] prev_state_q, prev_state_d;
    logic       prev_start_q, prev_start_d;
    logic       post_rst_q, post_rst_d;
    logic       filled_q, filled_d;
    logic       cafe_done_q, cafe_done_d;
    logic [7:0] cafe_count_q, cafe_count_d;
    logic       err_q, err_d;
    logic [2:0] err_code_q, err_code_d;

    logic       w_tc_viol;
    logic [2:0] w_tc_code;
    logic       w_viol;
    logic [2:0] w_code;

    maquina_trans_check u_trans_check (
        .prev_state (prev_state_q),
        .prev_start (prev_start_q),
        .state      (state),
        .filled     (filled_q),
        .viol       (w_tc_viol),
        .code       (w_tc_code)
    );

    always_comb begin
        prev_state_d = state;
        prev_start_d = start;
        post_rst_d   = 1'b0;
        filled_d     = filled_q | (state == ST_ENCHER);

        // The first sample after reset has no meaningful predecessor.
        w_viol = w_tc_viol;
        w_code = w_tc_code;
        if (post_rst_q) begin
            w_viol = 1'b0;
            w_code = C_ERR_NONE;
            if (!is_valid_state(state)) begin
                w_viol = 1'b1;
                w_code = C_ERR_INVALID;
            end else if (state != ST_IDLE) begin
                w_viol = 1'b1;
                w_code = C_ERR_RESET;
            end
        end

        cafe_done_d  = !post_rst_q && (prev_state_q == ST_EXTRACAO) && (state == ST_IDLE);
        cafe_count_d = cafe_count_q;
        if (cafe_done_d && (cafe_count_q != 8'hFF)) begin
            cafe_count_d = cafe_count_q + 8'd1;
        end

        // A violation beats a simultaneous clear; otherwise the first cause sticks.
        err_d      = err_q;
        err_code_d = err_code_q;
        if (w_viol) begin
            err_d = 1'b1;
            if (!err_q || err_clr) begin
                err_code_d = w_code;
            end
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_code_d = C_ERR_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_q <= ST_IDLE;
            prev_start_q <= 1'b0;
            post_rst_q   <= 1'b1;
            filled_q     <= 1'b0;
            cafe_done_q  <= 1'b0;
            cafe_count_q <= 8'd0;
            err_q        <= 1'b0;
            err_code_q   <= C_ERR_NONE;
        end else begin
            prev_state_q <= prev_state_d;
            prev_start_q <= prev_start_d;
            post_rst_q   <= post_rst_d;
            filled_q     <= filled_d;
            cafe_done_q  <= cafe_done_d;
            cafe_count_q <= cafe_count_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign busy        = !post_rst_q && (prev_state_q != ST_IDLE);
    assign cafe_done   = cafe_done_q;
    assign cafe_count  = cafe_count_q;
    assign refill_seen = filled_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_monitor_maquina.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_monitor_maquina: scoreboard bench for monitor_maquina          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_monitor_maquina;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] state;
    logic       start;
    logic       err_clr;
    logic       busy;
    logic       cafe_done;
    logic [7:0] cafe_count;
    logic       refill_seen;
    logic       err;
    logic [2:0] err_code;

    monitor_maquina dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .start       (start),
        .err_clr     (err_clr),
        .busy        (busy),
        .cafe_done   (cafe_done),
        .cafe_count  (cafe_count),
        .refill_seen (refill_seen),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       done;
        logic       busy;
        logic       refill;
        logic       err;
        logic [7:0] cnt;
        logic [2:0] code;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   total = 0;
    int   bad   = 0;

    // Hand-maintained expectation of the sticky/accumulated outputs.
    int   e_count  = 0;
    bit   e_refill = 1'b0;
    bit   e_err    = 1'b0;
    int   e_code   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_done"},   int'(cafe_done), 0);
        chk({tag, "_count"},  int'(cafe_count), 0);
        chk({tag, "_refill"}, int'(refill_seen), 0);
        chk({tag, "_err"},    int'(err), 0);
        chk({tag, "_code"},   int'(err_code), 0);
    endtask

    // One sampled cycle: drive inputs and queue what must appear after the edge.
    task automatic step(input logic [3:0] s, input logic st, input logic clr, input logic done);
        exp_t e;
        @(negedge clk);
        rst_n   = 1'b1;
        state   = s;
        start   = st;
        err_clr = clr;
        if (done && e_count < 255) e_count++;
        e.done   = done;
        e.busy   = (s != 4'd1);
        e.refill = e_refill;
        e.err    = e_err;
        e.cnt    = e_count[7:0];
        e.code   = e_code[2:0];
        q.push_back(e);
    endtask

    task automatic brew();
        step(4'd1, 1'b1, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd6, 1'b0, 1'b0, 1'b0);
        step(4'd7, 1'b0, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0, 1'b0);
        step(4'd9, 1'b0, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0, 1'b1);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            m_e = q.pop_front();
            chk("cafe_done",   int'(cafe_done),   int'(m_e.done));
            chk("busy",        int'(busy),        int'(m_e.busy));
            chk("refill_seen", int'(refill_seen), int'(m_e.refill));
            chk("err",         int'(err),         int'(m_e.err));
            chk("cafe_count",  int'(cafe_count),  int'(m_e.cnt));
            chk("err_code",    int'(err_code),    int'(m_e.code));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        state   = 4'd1;
        start   = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");

        // First brew with refill.
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd1, 1'b1, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0, 1'b0);
        e_refill = 1'b1;
        step(4'd4, 1'b0, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd6, 1'b0, 1'b0, 1'b0);
        step(4'd7, 1'b0, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0, 1'b0);
        step(4'd9, 1'b0, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0, 1'b1);
        step(4'd1, 1'b0, 1'b0, 1'b0);

        // Second brew, then a refill after the reservoir is already full.
        brew();
        step(4'd1, 1'b1, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0, 1'b0);
        e_err = 1'b1; e_code = 5;
        step(4'd4, 1'b0, 1'b0, 1'b0);

        // Clear and finish legally; the brew still counts.
        e_err = 1'b0; e_code = 0;
        step(4'd3, 1'b0, 1'b1, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd6, 1'b0, 1'b0, 1'b0);
        step(4'd7, 1'b0, 1'b0, 1'b0);
        step(4'd8, 1'b0, 1'b0, 1'b0);
        step(4'd9, 1'b0, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0, 1'b1);

        // Start without request, then a later illegal step keeps the first code.
        step(4'd1, 1'b0, 1'b0, 1'b0);
        e_err = 1'b1; e_code = 3;
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        e_err = 1'b0; e_code = 0;
        step(4'd6, 1'b0, 1'b1, 1'b0);

        // Invalid encoding, skipped check after it, violation beating clear.
        e_err = 1'b1; e_code = 1;
        step(4'd12, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        e_code = 2;
        step(4'd8, 1'b0, 1'b1, 1'b0);
        e_err = 1'b0; e_code = 0;
        step(4'd9, 1'b0, 1'b1, 1'b0);
        step(4'd1, 1'b0, 1'b0, 1'b1);

        // Saturation of the brew counter.
        repeat (300) brew();

        // Reset mid-brew, then a non-IDLE first sample.
        step(4'd1, 1'b1, 1'b0, 1'b0);
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd3, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midbrew_reset");
        e_count = 0; e_refill = 1'b0; e_err = 1'b1; e_code = 6;
        @(posedge clk);
        step(4'd5, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/monitor_maquina.md
MONITOR_MAQUINA -- requirements
Module: monitor_maquina

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the rising-edge clock shared with the coffee machine FSM.
REQ-002 The block SHALL have port rst_n, input, 1 bit, the reset (asynchronous, active-low).
REQ-003 The block SHALL have port state, input, 4 bits, the machine's current state as the machine drives it.
REQ-004 The block SHALL have port start, input, 1 bit, the same start request the machine receives.
REQ-005 The block SHALL have port err_clr, input, 1 bit, a synchronous clear of the sticky error.
REQ-006 The block SHALL have port busy, output, 1 bit, high while the last sampled state is not IDLE.
REQ-007 The block SHALL have port cafe_done, output, 1 bit, a one-cycle pulse for each completed brew.
REQ-008 The block SHALL have port cafe_count, output, 8 bits, the completed brews, saturating at 255.
REQ-009 The block SHALL have port refill_seen, output, 1 bit, high once ENCHER_RESERVATORIO has been observed.
REQ-010 The block SHALL have port err, output, 1 bit, a sticky protocol-violation flag.
REQ-011 The block SHALL have port err_code, output, 3 bits, the cause of the first violation since the last clear.

Function
REQ-012 The encoding SHALL be IDLE=1, LIGAR_MAQUINA=2, VERIFICAR_AGUA=3, ENCHER_RESERVATORIO=4, MOER_CAFE=5, COLOCAR_NO_FILTRO=6, PASSAR_AGITADOR=7, TAMPEAR=8, REALIZAR_EXTRACAO=9; any other value is invalid.
REQ-013 On each clk rising edge the block SHALL register state and start as prev_state and prev_start.
REQ-014 On each edge the block SHALL check the pair (prev_state, prev_start) -> state, so results appear one cycle after the offending state.
REQ-015 The legal transitions SHALL be:
- IDLE->LIGAR only if prev_start=1; IDLE->IDLE only if prev_start=0.
- LIGAR->VERIFICAR.
- VERIFICAR->ENCHER only if filled=0; VERIFICAR->MOER only if filled=1.
- ENCHER->VERIFICAR.
- MOER->COLOCAR->PASSAR->TAMPEAR->EXTRACAO->IDLE.
REQ-016 The error codes SHALL be:
- 1: invalid encoding.
- 2: any other illegal transition.
- 3: IDLE->LIGAR with prev_start=0.
- 4: IDLE->IDLE with prev_start=1.
- 5: refill-order violation per REQ-015.
- 6: first sample after reset is not IDLE.
REQ-017 The internal filled flag SHALL set on the edge that samples state=ENCHER and SHALL clear only on reset; refill_seen SHALL equal filled.
REQ-018 If prev_state is invalid, the block SHALL perform no transition check on the next sample.
REQ-019 An invalid state value SHALL raise code 1 only.
REQ-020 A post-reset flag SHALL suppress the transition check on the first sample and SHALL apply the code 6 check instead.
REQ-021 On a violation with err=0, the block SHALL set err=1 and latch err_code.
REQ-022 On a violation with err=1, err_code SHALL be held, so the first cause wins.
REQ-023 err_clr=1 SHALL clear err and err_code to 0 on the next edge.
REQ-024 If err_clr and a violation occur on the same edge, the violation SHALL win: err=1 with the new code.
REQ-025 cafe_done SHALL pulse for exactly one cycle on the edge that samples EXTRACAO->IDLE as a legal transition.
REQ-026 cafe_count SHALL increment on the same edge as cafe_done, holding at 255 without wrapping.
REQ-027 A brew ending in a violation SHALL still count if its final EXTRACAO->IDLE step is legal.
REQ-028 busy SHALL equal (registered prev_state != IDLE) and SHALL be 0 while the post-reset flag is set.

Reset
REQ-029 On rst_n=0 all of the following SHALL reset asynchronously, with outputs reading 0 during reset:
- prev_state=IDLE, prev_start=0, post-reset flag=1.
- filled=0, cafe_count=0, cafe_done=0, err=0, err_code=0, busy=0.
REQ-030 Reset asserted mid-brew SHALL discard all tracking.
REQ-031 After reset, the first sample SHALL be checked per REQ-020.

Structure
REQ-032 The state encodings (REQ-012) and err_code values (REQ-016) SHALL be defined in a shared package, maquina_pkg, used by both the machine and this monitor.
REQ-033 The transition legality check SHALL be a combinational sub-module, maquina_trans_check, with inputs prev_state, prev_start, state and filled, and outputs viol and code.
REQ-034 All registers, counters and sticky logic SHALL reside in monitor_maquina.

Verification
REQ-035 Release reset, hold state=1, pulse start, then drive the legal first brew 1,2,3,4,3,5,6,7,8,9,1 -> one cafe_done pulse, cafe_count=1, refill_seen=1, err=0.
REQ-036 After REQ-035, drive the second brew 2,3,5,...,9,1 -> cafe_count=2, err=0; then drive 2,3,4 -> err=1, err_code=5 one cycle after state=4.
REQ-037 Drive state=1 with prev_start=0, then state=2 -> err_code=3.
REQ-038 Drive state=12 -> err_code=1.
REQ-039 With err=1 and err_code=1, drive state 5->8 (code 2) while asserting err_clr on the same edge -> err=1, err_code=2.
REQ-040 Drive 300 legal brews -> cafe_count holds 255.
REQ-041 Assert rst_n=0 mid-brew at state=6 -> outputs 0 immediately; then drive state=5 as the first sample -> err_code=6.
